snax_hypercorex_pred_packer: RTL and testbench

- Parametrised next-generation output stage for the Hypercorex shell, placed between the hypercorex_top prediction port and the narrow acc2stream writer channel.
- The current shell sends one zero-padded CsrDataWidth prediction per NarrowDataWidth beat. This block packs up to PackNum predictions into each beat.
- Adds a runtime pack/pass-through mode, an explicit partial-word flush, per-beat lane count, and a running prediction counter.

---
 rtl/snax_hypercorex_pkg.sv | 20 ++
 rtl/snax_hypercorex_out_stage.sv | 35 +++
 rtl/snax_hypercorex_pred_packer.sv | 105 ++++++++++
 tb/tb_snax_hypercorex_pred_packer.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snax_hypercorex_pkg.sv
// Shared sizing helpers and lane typedef for the Hypercorex prediction packer.
package snax_hypercorex_pkg;

  function automatic int unsigned calc_pack_num(input int unsigned narrow_w,
                                                input int unsigned pred_w);
    return narrow_w / pred_w;
  endfunction

  // Lane counter must be able to represent PackNum itself, not just PackNum-1.
  function automatic int unsigned lane_cnt_w(input int unsigned pack_num);
    return (pack_num < 1) ? 1 : $clog2(pack_num + 1);
  endfunction

  localparam int unsigned DefNarrowDataWidth = 64;
  localparam int unsigned DefPredWidth       = 32;
  localparam int unsigned DefPackNum         = calc_pack_num(DefNarrowDataWidth, DefPredWidth);

  typedef logic [DefPackNum-1:0][DefPredWidth-1:0] pred_lanes_t;

endpackage

// File: rtl/snax_hypercorex_out_stage.sv
// Single-entry valid/ready output register carrying a beat and its lane count.
module snax_hypercorex_out_stage #(
  parameter int unsigned DataWidth  = 64,
  parameter int unsigned CountWidth = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  load_i,
  input  logic [DataWidth-1:0]  data_i,
  input  logic [CountWidth-1:0] count_i,
  input  logic                  pop_i,
  output logic                  ready_o,
  output logic                  valid_o,
  output logic [DataWidth-1:0]  data_o,
  output logic [CountWidth-1:0] count_o
);

  // Free now, or freed by the handshake happening this cycle.
  assign ready_o = !valid_o || pop_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_o <= 1'b0;
      data_o  <= '0;
      count_o <= '0;
    end else if (load_i) begin
      valid_o <= 1'b1;
      data_o  <= data_i;
      count_o <= count_i;
    end else if (pop_i && valid_o) begin
      valid_o <= 1'b0;
    end
  end

endmodule

// File: rtl/snax_hypercorex_pred_packer.sv
// Packs up to PackNum predictions per narrow beat, with pass-through mode and flush.
module snax_hypercorex_pred_packer
  import snax_hypercorex_pkg::*;
#(
  parameter int unsigned NarrowDataWidth = 64,
  parameter int unsigned PredWidth       = 32,
  parameter int unsigned PackNum         = calc_pack_num(NarrowDataWidth, PredWidth),
  parameter int unsigned CntWidth        = 32
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               pack_en_i,
  input  logic                               flush_i,
  input  logic [PredWidth-1:0]               pred_data_i,
  input  logic                               pred_valid_i,
  output logic                               pred_ready_o,
  output logic [NarrowDataWidth-1:0]         out_data_o,
  output logic                               out_valid_o,
  input  logic                               out_ready_i,
  output logic [lane_cnt_w(PackNum)-1:0]     out_count_o,
  output logic [CntWidth-1:0]                pred_cnt_o,
  output logic                               busy_o
);

  localparam int unsigned CW = lane_cnt_w(PackNum);

  if (PackNum < 1 || PackNum * PredWidth > NarrowDataWidth) begin : g_bad_cfg
    $error("snax_hypercorex_pred_packer: PackNum lanes do not fit in NarrowDataWidth");
  end

  typedef logic [PackNum-1:0][PredWidth-1:0] lanes_t;

  lanes_t              lanes_q, lanes_d;
  logic [CW-1:0]       fill_q, fill_d, cap;
  logic                mode_q;
  logic                flush_pend_q, flush_pend_d;
  logic                full, flushing, xfer, accept, can_load;
  logic [CntWidth-1:0] pred_cnt_q;

  assign cap      = mode_q ? CW'(PackNum) : CW'(1);
  assign full     = (fill_q == cap);
  assign flushing = flush_pend_q && (fill_q != '0);
  assign xfer     = (full || flushing) && can_load;

  // A pending partial flush freezes the word so it leaves exactly as flushed.
  assign pred_ready_o = ((fill_q < cap) && !flushing) || xfer;
  assign accept       = pred_valid_i && pred_ready_o;

  always_comb begin
    lanes_d = lanes_q;
    fill_d  = fill_q;
    if (xfer) begin
      lanes_d = '0;
      fill_d  = '0;
    end
    if (accept) begin
      for (int i = 0; i < PackNum; i++)
        if (fill_d == CW'(i)) lanes_d[i] = pred_data_i;
      fill_d = fill_d + CW'(1);
    end
  end

  always_comb begin
    flush_pend_d = flush_pend_q;
    if (flush_pend_q && ((fill_q == '0) || xfer)) flush_pend_d = 1'b0;
    if (flush_i) flush_pend_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lanes_q      <= '0;
      fill_q       <= '0;
      mode_q       <= 1'b0;
      flush_pend_q <= 1'b0;
      pred_cnt_q   <= '0;
    end else begin
      lanes_q      <= lanes_d;
      fill_q       <= fill_d;
      flush_pend_q <= flush_pend_d;
      // Mode only switches between words, never inside one.
      if (fill_q == '0) mode_q <= pack_en_i;
      if (accept) pred_cnt_q <= pred_cnt_q + CntWidth'(1);
    end
  end

  snax_hypercorex_out_stage #(
    .DataWidth  (NarrowDataWidth),
    .CountWidth (CW)
  ) u_out_stage (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .load_i  (xfer),
    .data_i  (NarrowDataWidth'(lanes_q)),
    .count_i (fill_q),
    .pop_i   (out_ready_i),
    .ready_o (can_load),
    .valid_o (out_valid_o),
    .data_o  (out_data_o),
    .count_o (out_count_o)
  );

  assign pred_cnt_o = pred_cnt_q;
  assign busy_o     = (fill_q != '0) || out_valid_o || flush_pend_q;

endmodule

// File: tb/tb_snax_hypercorex_pred_packer.sv
// Bench for the prediction packer: 64-bit (2 lanes) and 128-bit (4 lanes) instances.
module tb_snax_hypercorex_pred_packer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        pack_en[2], flush[2], pvalid[2], oready[2];
  logic [31:0] pdata[2];
  logic        pready[2], ovalid[2], busy[2];
  logic [127:0] odata[2];
  logic [2:0]  ocount[2];
  logic [31:0] pcnt[2];

  logic [63:0]  od0;
  logic [1:0]   oc0;
  logic [127:0] od1;
  logic [2:0]   oc1;
  assign odata[0]  = {64'd0, od0};
  assign ocount[0] = {1'b0, oc0};
  assign odata[1]  = od1;
  assign ocount[1] = oc1;

  snax_hypercorex_pred_packer #(.NarrowDataWidth(64)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .pack_en_i(pack_en[0]), .flush_i(flush[0]),
    .pred_data_i(pdata[0]), .pred_valid_i(pvalid[0]), .pred_ready_o(pready[0]),
    .out_data_o(od0), .out_valid_o(ovalid[0]), .out_ready_i(oready[0]),
    .out_count_o(oc0), .pred_cnt_o(pcnt[0]), .busy_o(busy[0]));

  snax_hypercorex_pred_packer #(.NarrowDataWidth(128)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .pack_en_i(pack_en[1]), .flush_i(flush[1]),
    .pred_data_i(pdata[1]), .pred_valid_i(pvalid[1]), .pred_ready_o(pready[1]),
    .out_data_o(od1), .out_valid_o(ovalid[1]), .out_ready_i(oready[1]),
    .out_count_o(oc1), .pred_cnt_o(pcnt[1]), .busy_o(busy[1]));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  // Word-level model: predictions gather into words; a word becomes an
  // expected beat once it holds cap predictions or a flush closes it.
  int           pn[2] = '{2, 4};
  logic [31:0]  wrd[2][4];
  int           wsz[2];
  logic         mode_m[2], fl_m[2];
  logic [127:0] exp_d[2][64];
  int           exp_c[2][64];
  int           eh[2], et[2];
  logic [31:0]  cnt_m[2];
  logic         hold[2];
  logic [127:0] hold_d[2];
  logic [2:0]   hold_c[2];
  logic [127:0] log_d[2][64];
  int           log_c[2][64], log_t[2][64];
  int           log_n[2] = '{0, 0};
  int           cyc = 0;

  task automatic push_word(input int k);
    logic [127:0] b;
    b = '0;
    for (int i = 0; i < wsz[k]; i++) b = b | (128'(wrd[k][i]) << (32 * i));
    exp_d[k][et[k] % 64] = b;
    exp_c[k][et[k] % 64] = wsz[k];
    et[k]++;
    wsz[k] = 0;
  endtask

  always @(negedge clk) begin
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        wsz[k] = 0; fl_m[k] = 1'b0; mode_m[k] = 1'b0;
        eh[k] = 0; et[k] = 0; cnt_m[k] = '0; hold[k] = 1'b0;
      end else begin
        chk($sformatf("pred_cnt%0d", k), pcnt[k], cnt_m[k]);
        if (hold[k]) begin
          chk($sformatf("hold_valid%0d", k), ovalid[k], 1);
          chk($sformatf("hold_data%0d", k), odata[k], hold_d[k]);
          chk($sformatf("hold_count%0d", k), ocount[k], hold_c[k]);
        end
        if (ovalid[k]) begin
          chk($sformatf("count_range%0d", k), (ocount[k] >= 1 && ocount[k] <= pn[k]), 1);
          chk($sformatf("unused_lanes%0d", k), odata[k] >> (32 * ocount[k]), 0);
        end
        if (ovalid[k] && oready[k]) begin
          if (eh[k] == et[k]) chk($sformatf("beat_expected%0d", k), et[k] - eh[k], 1);
          else begin
            chk($sformatf("beat_data%0d", k), odata[k], exp_d[k][eh[k] % 64]);
            chk($sformatf("beat_count%0d", k), ocount[k], exp_c[k][eh[k] % 64]);
            eh[k]++;
          end
          if (log_n[k] < 64) begin
            log_d[k][log_n[k]] = odata[k];
            log_c[k][log_n[k]] = ocount[k];
            log_t[k][log_n[k]] = cyc;
            log_n[k]++;
          end
        end
        hold[k]   = ovalid[k] && !oready[k];
        hold_d[k] = odata[k];
        hold_c[k] = ocount[k];
        if (wsz[k] == 0) mode_m[k] = pack_en[k];
        if (pvalid[k] && pready[k]) begin
          wrd[k][wsz[k]] = pdata[k];
          wsz[k]++;
          cnt_m[k] = cnt_m[k] + 1;
        end
        if (wsz[k] == (mode_m[k] ? pn[k] : 1)) push_word(k);
        if (flush[k]) fl_m[k] = 1'b1;
        if (fl_m[k]) begin
          if (wsz[k] > 0) push_word(k);
          fl_m[k] = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input int k, input logic [31:0] d, output logic r);
    pvalid[k] = 1'b1;
    pdata[k]  = d;
    #1 r = pready[k];
    @(posedge clk);
    #2;
  endtask

  logic r;
  int n0, n1, acc;
  logic [31:0] v4[5];
  logic [31:0] v1[4];

  initial begin
    for (int k = 0; k < 2; k++) begin
      pack_en[k] = 1'b1; flush[k] = 1'b0; pvalid[k] = 1'b0; oready[k] = 1'b1; pdata[k] = '0;
    end
    repeat (2) @(posedge clk);
    #3;
    for (int k = 0; k < 2; k++) begin
      chk("rst_ready", pready[k], 1);
      chk("rst_valid", ovalid[k], 0);
      chk("rst_data", odata[k], 0);
      chk("rst_count", ocount[k], 0);
      chk("rst_cnt", pcnt[k], 0);
      chk("rst_busy", busy[k], 0);
    end
    @(posedge clk);
    #2 rst_n = 1'b1;
    tick(); tick();

    // 1: packed, back-to-back
    n0 = log_n[0];
    v1 = '{32'hA, 32'hB, 32'hC, 32'hD};
    for (int i = 0; i < 4; i++) begin
      send(0, v1[i], r);
      chk("t1_ready", r, 1);
    end
    pvalid[0] = 1'b0;
    repeat (4) tick();
    chk("t1_nbeats", log_n[0] - n0, 2);
    chk("t1_beat0", log_d[0][n0], 128'h0000000B_0000000A);
    chk("t1_cnt0", log_c[0][n0], 2);
    chk("t1_beat1", log_d[0][n0+1], 128'h0000000D_0000000C);
    chk("t1_cnt1", log_c[0][n0+1], 2);
    chk("t1_pcnt", pcnt[0], 4);

    // 2: legacy pass-through
    pack_en[0] = 1'b0;
    n0 = log_n[0];
    send(0, 32'h11, r); chk("t2_ready0", r, 1);
    send(0, 32'h22, r); chk("t2_ready1", r, 1);
    pvalid[0] = 1'b0;
    repeat (4) tick();
    chk("t2_nbeats", log_n[0] - n0, 2);
    chk("t2_beat0", log_d[0][n0], 128'h11);
    chk("t2_cnt0", log_c[0][n0], 1);
    chk("t2_beat1", log_d[0][n0+1], 128'h22);
    chk("t2_cnt1", log_c[0][n0+1], 1);
    chk("t2_gap", log_t[0][n0+1] - log_t[0][n0], 1);

    // 3: 4-lane partial flush, then empty flush
    n1 = log_n[1];
    send(1, 32'd1, r); send(1, 32'd2, r); send(1, 32'd3, r);
    pvalid[1] = 1'b0;
    flush[1] = 1'b1; tick(); flush[1] = 1'b0;
    repeat (4) tick();
    chk("t3_nbeats", log_n[1] - n1, 1);
    chk("t3_beat", log_d[1][n1], 128'h00000000_00000003_00000002_00000001);
    chk("t3_cnt", log_c[1][n1], 3);
    chk("t3_idle_busy", busy[1], 0);
    flush[1] = 1'b1; tick(); flush[1] = 1'b0;
    chk("t3_flush_busy", busy[1], 1);
    tick();
    chk("t3_busy_fall", busy[1], 0);
    repeat (3) tick();
    chk("t3_no_empty_beat", log_n[1] - n1, 1);

    // 4: backpressure
    pack_en[0] = 1'b1;
    tick();
    oready[0] = 1'b0;
    v4 = '{32'h31, 32'h32, 32'h33, 32'h34, 32'h35};
    n0 = log_n[0];
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      send(0, v4[acc], r);
      if (r) acc++;
    end
    chk("t4_accepted", acc, 4);
    chk("t4_ready_low", pready[0], 0);
    chk("t4_held_valid", ovalid[0], 1);
    chk("t4_held_data", odata[0], 128'h00000032_00000031);
    oready[0] = 1'b1;
    send(0, v4[4], r);
    chk("t4_fifth_accept", r, 1);
    pvalid[0] = 1'b0;
    repeat (3) tick();
    flush[0] = 1'b1; tick(); flush[0] = 1'b0;
    repeat (4) tick();
    chk("t4_nbeats", log_n[0] - n0, 3);
    chk("t4_beat0", log_d[0][n0], 128'h00000032_00000031);
    chk("t4_beat1", log_d[0][n0+1], 128'h00000034_00000033);
    chk("t4_beat2", log_d[0][n0+2], 128'h35);
    chk("t4_cnt2", log_c[0][n0+2], 1);

    // 5: mode change mid-word waits for the word boundary
    n0 = log_n[0];
    send(0, 32'h51, r);
    pack_en[0] = 1'b0;
    send(0, 32'h52, r);
    pvalid[0] = 1'b0;
    repeat (3) tick();
    send(0, 32'h53, r);
    pvalid[0] = 1'b0;
    repeat (3) tick();
    chk("t5_nbeats", log_n[0] - n0, 2);
    chk("t5_beat0", log_d[0][n0], 128'h00000052_00000051);
    chk("t5_cnt0", log_c[0][n0], 2);
    chk("t5_beat1", log_d[0][n0+1], 128'h53);
    chk("t5_cnt1", log_c[0][n0+1], 1);

    // 6: asynchronous reset mid-word
    pack_en[0] = 1'b1;
    tick();
    oready[0] = 1'b0;
    send(0, 32'h61, r); send(0, 32'h62, r); send(0, 32'h63, r);
    pvalid[0] = 1'b0;
    tick();
    chk("t6_pre_valid", ovalid[0], 1);
    chk("t6_pre_busy", busy[0], 1);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", ovalid[0], 0);
    chk("t6_rst_data", odata[0], 0);
    chk("t6_rst_count", ocount[0], 0);
    chk("t6_rst_cnt", pcnt[0], 0);
    chk("t6_rst_busy", busy[0], 0);
    chk("t6_rst_ready", pready[0], 1);
    @(posedge clk);
    #2 rst_n = 1'b1;
    oready[0] = 1'b1;
    tick();
    n0 = log_n[0];
    send(0, 32'h71, r); send(0, 32'h72, r);
    pvalid[0] = 1'b0;
    repeat (4) tick();
    chk("t6_nbeats", log_n[0] - n0, 1);
    chk("t6_beat", log_d[0][n0], 128'h00000072_00000071);
    chk("t6_pcnt", pcnt[0], 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
